// File: rtl/lsu_wb_pkg.sv
// Shared definitions for the load/store-to-writeback stage: widths, load-size
// encodings, FSM states and the load alignment rule.
package lsu_wb_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [1:0] LS_SIZE_B = 2'b00;
    localparam logic [1:0] LS_SIZE_H = 2'b01;
    localparam logic [1:0] LS_SIZE_W = 2'b10;
    localparam logic [1:0] LS_SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10
    } lsu_state_e;

    // A load is misaligned when its byte offset is not a multiple of its size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            LS_SIZE_B: mis = 1'b0;
            LS_SIZE_H: mis = off[0];
            LS_SIZE_W: mis = |off[1:0];
            default:   mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_wb_load_align.sv
// Selects the addressed lane of a 64-bit read beat and sign- or zero-extends
// it to a full register value.
module load_align
    import lsu_wb_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      addr_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic [31:0] wordLane;

    assign byteLane = rdata_i[{addr_i, 3'b000} +: 8];
    assign halfLane = rdata_i[{addr_i[2:1], 4'b0000} +: 16];
    assign wordLane = rdata_i[{addr_i[2], 5'b00000} +: 32];

    // Double-width loads fill the register, so the unsigned flag has no effect.
    always_comb begin
        data_o = rdata_i;
        case (size_i)
            LS_SIZE_B: data_o = {{56{byteLane[7]  & ~unsigned_i}}, byteLane};
            LS_SIZE_H: data_o = {{48{halfLane[15] & ~unsigned_i}}, halfLane};
            LS_SIZE_W: data_o = {{32{wordLane[31] & ~unsigned_i}}, wordLane};
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_wb_stage.sv
// Load/store-to-writeback stage: retires ALU results directly and performs one
// bus read per load, aligning and extending the returned data.
module lsu_wb_stage #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EX_LS_reg_execute_valid,
    output logic            LS_EX_reg_ready,
    input  logic [4:0]      EX_LS_reg_rd,
    input  logic            EX_LS_reg_dest_wen,
    input  logic            EX_LS_reg_trap_valid,
    input  logic            EX_LS_reg_load_valid,
    input  logic [1:0]      EX_LS_reg_load_size,
    input  logic            EX_LS_reg_load_unsigned,
    input  logic [XLEN-1:0] EX_LS_reg_result,
    output logic            ls_rd_req,
    output logic [XLEN-1:0] ls_rd_addr,
    input  logic            ls_rd_gnt,
    input  logic            ls_rd_rvalid,
    input  logic [XLEN-1:0] ls_rd_rdata,
    input  logic            ls_rd_rerr,
    output logic            LS_WB_reg_ls_valid,
    output logic            LS_WB_reg_trap_valid,
    output logic [4:0]      LS_WB_reg_rd,
    output logic            LS_WB_reg_dest_wen,
    output logic [XLEN-1:0] LS_WB_reg_data
);
    import lsu_wb_pkg::*;

    lsu_state_e      state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic            wen_q, wen_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            wbValid_q, wbValid_d;
    logic            wbTrap_q, wbTrap_d;
    logic [4:0]      wbRd_q, wbRd_d;
    logic            wbWen_q, wbWen_d;
    logic [XLEN-1:0] wbData_q, wbData_d;

    logic [XLEN-1:0] alignedData;

    load_align u_load_align (
        .rdata_i    (ls_rd_rdata),
        .addr_i     (result_q[2:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (alignedData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LSU_IDLE;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            result_q  <= '0;
            wbValid_q <= 1'b0;
            wbTrap_q  <= 1'b0;
            wbRd_q    <= '0;
            wbWen_q   <= 1'b0;
            wbData_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            result_q  <= result_d;
            wbValid_q <= wbValid_d;
            wbTrap_q  <= wbTrap_d;
            wbRd_q    <= wbRd_d;
            wbWen_q   <= wbWen_d;
            wbData_q  <= wbData_d;
        end
    end

    // Write-back fields hold their last value; only the valid strobe self-clears.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        size_d    = size_q;
        uns_d     = uns_q;
        result_d  = result_q;
        wbValid_d = 1'b0;
        wbTrap_d  = wbTrap_q;
        wbRd_d    = wbRd_q;
        wbWen_d   = wbWen_q;
        wbData_d  = wbData_q;

        case (state_q)
            LSU_IDLE: begin
                if (EX_LS_reg_execute_valid) begin
                    rd_d     = EX_LS_reg_rd;
                    wen_d    = EX_LS_reg_dest_wen;
                    size_d   = EX_LS_reg_load_size;
                    uns_d    = EX_LS_reg_load_unsigned;
                    result_d = EX_LS_reg_result;
                    if (!EX_LS_reg_load_valid || EX_LS_reg_trap_valid ||
                        is_misaligned(EX_LS_reg_load_size, EX_LS_reg_result[2:0])) begin
                        // Misaligned loads report the faulting address as data.
                        wbValid_d = 1'b1;
                        wbTrap_d  = EX_LS_reg_trap_valid | EX_LS_reg_load_valid;
                        wbRd_d    = EX_LS_reg_rd;
                        wbWen_d   = EX_LS_reg_dest_wen;
                        wbData_d  = EX_LS_reg_result;
                    end else begin
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (ls_rd_gnt) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (ls_rd_rvalid) begin
                    state_d   = LSU_IDLE;
                    wbValid_d = 1'b1;
                    wbTrap_d  = ls_rd_rerr;
                    wbRd_d    = rd_q;
                    wbWen_d   = wen_q;
                    wbData_d  = ls_rd_rerr ? '0 : alignedData;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    assign LS_EX_reg_ready      = (state_q == LSU_IDLE);
    assign ls_rd_req            = (state_q == LSU_REQ);
    assign ls_rd_addr           = (state_q == LSU_REQ) ? {result_q[XLEN-1:3], 3'b000} : '0;
    assign LS_WB_reg_ls_valid   = wbValid_q;
    assign LS_WB_reg_trap_valid = wbTrap_q;
    assign LS_WB_reg_rd         = wbRd_q;
    assign LS_WB_reg_dest_wen   = wbWen_q;
    assign LS_WB_reg_data       = wbData_q;

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Randomized self-checking bench for lsu_wb_stage with a behavioural load model.
module tb_lsu_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exValid = 1'b0;
    logic        ready;
    logic [4:0]  exRd = '0;
    logic        exWen = 1'b0;
    logic        exTrap = 1'b0;
    logic        exLoad = 1'b0;
    logic [1:0]  exSize = '0;
    logic        exUns = 1'b0;
    logic [63:0] exResult = '0;
    logic        rdReq;
    logic [63:0] rdAddr;
    logic        rdGnt = 1'b0;
    logic        rdRvalid = 1'b0;
    logic [63:0] rdRdata = '0;
    logic        rdRerr = 1'b0;
    logic        wbValid;
    logic        wbTrap;
    logic [4:0]  wbRd;
    logic        wbWen;
    logic [63:0] wbData;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    lsu_wb_stage dut (
        .clk                     (clk),
        .rst                     (rst),
        .EX_LS_reg_execute_valid (exValid),
        .LS_EX_reg_ready         (ready),
        .EX_LS_reg_rd            (exRd),
        .EX_LS_reg_dest_wen      (exWen),
        .EX_LS_reg_trap_valid    (exTrap),
        .EX_LS_reg_load_valid    (exLoad),
        .EX_LS_reg_load_size     (exSize),
        .EX_LS_reg_load_unsigned (exUns),
        .EX_LS_reg_result        (exResult),
        .ls_rd_req               (rdReq),
        .ls_rd_addr              (rdAddr),
        .ls_rd_gnt               (rdGnt),
        .ls_rd_rvalid            (rdRvalid),
        .ls_rd_rdata             (rdRdata),
        .ls_rd_rerr              (rdRerr),
        .LS_WB_reg_ls_valid      (wbValid),
        .LS_WB_reg_trap_valid    (wbTrap),
        .LS_WB_reg_rd            (wbRd),
        .LS_WB_reg_dest_wen      (wbWen),
        .LS_WB_reg_data          (wbData)
    );

    // Value of an n-byte field starting at byte a, extended to 64 bits.
    function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [2:0] a,
                                               input logic [1:0] size, input bit uns);
        int nbits;
        logic [63:0] v;
        logic [63:0] mask;
        nbits = 8 << size;
        v = rdata >> (8 * int'(a));
        if (nbits < 64) begin
            mask = (64'd1 << nbits) - 64'd1;
            v = v & mask;
            if (!uns && v[nbits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [63:0] addr, input logic [1:0] size);
        int nbytes;
        nbytes = 1 << size;
        return (int'(addr[2:0]) % nbytes) != 0;
    endfunction

    task automatic drive_idle();
        exValid = 1'b0; exLoad = 1'b0; exTrap = 1'b0;
        rdGnt = 1'b0; rdRvalid = 1'b0; rdRerr = 1'b0;
    endtask

    // Instruction that retires from IDLE without a bus read.
    task automatic run_direct(input string tag, input logic [4:0] rd, input bit wen, input bit trapIn,
                              input bit isLoad, input logic [1:0] size, input bit uns,
                              input logic [63:0] result);
        bit expTrap;
        bit checkData;
        expTrap = trapIn || isLoad;
        checkData = !isLoad || trapIn;
        @(negedge clk);
        exValid = 1'b1; exRd = rd; exWen = wen; exTrap = trapIn; exLoad = isLoad;
        exSize = size; exUns = uns; exResult = result;
        @(negedge clk);
        drive_idle();
        testsRun++;
        if (wbValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL %s valid: got %b want 1", tag, wbValid); end
        testsRun++;
        if (wbTrap !== expTrap) begin testsFailed++; $display("[TB] FAIL %s trap: got %b want %b", tag, wbTrap, expTrap); end
        testsRun++;
        if (wbRd !== rd || wbWen !== wen) begin testsFailed++; $display("[TB] FAIL %s rd/wen: got %0d/%b want %0d/%b", tag, wbRd, wbWen, rd, wen); end
        if (checkData) begin
            testsRun++;
            if (wbData !== result) begin testsFailed++; $display("[TB] FAIL %s data: got %h want %h", tag, wbData, result); end
        end
        testsRun++;
        if (rdReq !== 1'b0 || ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL %s req/ready: got %b/%b want 0/1", tag, rdReq, ready); end
        @(negedge clk);
        testsRun++;
        if (wbValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL %s pulse width: got %b want 0", tag, wbValid); end
    endtask

    // Aligned load with gntDly REQ cycles before grant and rvDly WAIT cycles before data.
    task automatic run_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                            input bit uns, input logic [63:0] rdata, input bit rerr,
                            input int gntDly, input int rvDly, input logic [4:0] rd, input bit wen);
        logic [63:0] expAddr;
        logic [63:0] expData;
        expAddr = {addr[63:3], 3'b000};
        expData = rerr ? 64'd0 : model_load(rdata, addr[2:0], size, uns);
        @(negedge clk);
        exValid = 1'b1; exRd = rd; exWen = wen; exTrap = 1'b0; exLoad = 1'b1;
        exSize = size; exUns = uns; exResult = addr;
        @(negedge clk);
        drive_idle();
        exResult = {$urandom, $urandom};
        for (int i = 0; i <= gntDly; i++) begin
            testsRun++;
            if (rdReq !== 1'b1 || rdAddr !== expAddr) begin testsFailed++; $display("[TB] FAIL %s req hold: got %b/%h want 1/%h", tag, rdReq, rdAddr, expAddr); end
            testsRun++;
            if (ready !== 1'b0 || wbValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL %s busy in req: ready/valid got %b/%b want 0/0", tag, ready, wbValid); end
            if (i == gntDly) rdGnt = 1'b1;
            @(negedge clk);
        end
        rdGnt = 1'b0;
        for (int i = 0; i <= rvDly; i++) begin
            testsRun++;
            if (rdReq !== 1'b0 || ready !== 1'b0 || wbValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL %s wait: req/ready/valid got %b/%b/%b want 0/0/0", tag, rdReq, ready, wbValid); end
            if (i == rvDly) begin
                rdRvalid = 1'b1; rdRdata = rdata; rdRerr = rerr;
            end
            @(negedge clk);
        end
        drive_idle();
        rdRdata = {$urandom, $urandom};
        testsRun++;
        if (wbValid !== 1'b1 || wbTrap !== rerr) begin testsFailed++; $display("[TB] FAIL %s retire valid/trap: got %b/%b want 1/%b", tag, wbValid, wbTrap, rerr); end
        testsRun++;
        if (wbData !== expData) begin testsFailed++; $display("[TB] FAIL %s data: got %h want %h", tag, wbData, expData); end
        testsRun++;
        if (wbRd !== rd || wbWen !== wen) begin testsFailed++; $display("[TB] FAIL %s rd/wen: got %0d/%b want %0d/%b", tag, wbRd, wbWen, rd, wen); end
        @(negedge clk);
        testsRun++;
        if (wbValid !== 1'b0 || ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL %s after retire valid/ready: got %b/%b want 0/1", tag, wbValid, ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (wbValid !== 1'b0 || wbTrap !== 1'b0 || wbRd !== 5'd0 || wbWen !== 1'b0 || wbData !== 64'd0) begin
            testsFailed++; $display("[TB] FAIL reset wb: got %b/%b/%0d/%b/%h want all 0", wbValid, wbTrap, wbRd, wbWen, wbData);
        end
        testsRun++;
        if (rdReq !== 1'b0 || rdAddr !== 64'd0 || ready !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL reset bus/ready: got %b/%h/%b want 0/0/1", rdReq, rdAddr, ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_nonload();
        run_direct("nonload", 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'h1234);
        run_direct("trap_in", 5'd9, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 64'hCAFE_0000_0000_0001);
    endtask

    task automatic test_byte_load();
        run_load("lb_signed", 64'hDEAD_BEEF_0000_1003, 2'b00, 1'b0, 64'h0000_0000_8000_0000, 1'b0, 0, 0, 5'd7, 1'b1);
        run_load("lbu", 64'hDEAD_BEEF_0000_1003, 2'b00, 1'b1, 64'h0000_0000_8000_0000, 1'b0, 0, 0, 5'd8, 1'b1);
    endtask

    task automatic test_word_delayed();
        run_load("lw_delayed", 64'h0000_0040_0000_2004, 2'b10, 1'b0, 64'h9ABC_DEF0_1234_5678, 1'b0, 3, 2, 5'd11, 1'b1);
    endtask

    task automatic test_faults();
        run_direct("lh_misaligned", 5'd3, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 64'h0000_0000_0000_1001);
        run_load("ld_rerr", 64'h0000_0000_0000_3008, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 1, 5'd12, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        exValid = 1'b1; exRd = 5'd20; exWen = 1'b1; exLoad = 1'b1; exTrap = 1'b0;
        exSize = 2'b11; exUns = 1'b0; exResult = 64'h0000_0000_0000_4000;
        @(negedge clk);
        drive_idle();
        rdGnt = 1'b1;
        @(negedge clk);
        rdGnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rdRvalid = 1'b1; rdRdata = 64'h1111_2222_3333_4444;
        testsRun++;
        if (ready !== 1'b1 || rdReq !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid ready/req: got %b/%b want 1/0", ready, rdReq); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rdRvalid = 1'b0;
            testsRun++;
            if (wbValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid stale retire: got %b want 0", wbValid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds[3];
        logic [63:0] res[3];
        for (int i = 0; i < 3; i++) begin
            rds[i] = 5'(i + 1);
            res[i] = {$urandom, $urandom};
        end
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                testsRun++;
                if (wbValid !== 1'b1 || wbRd !== rds[i-1] || wbData !== res[i-1]) begin
                    testsFailed++; $display("[TB] FAIL b2b[%0d]: got %b/%0d/%h want 1/%0d/%h", i-1, wbValid, wbRd, wbData, rds[i-1], res[i-1]);
                end
                testsRun++;
                if (ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b[%0d] ready: got %b want 1", i-1, ready); end
            end
            if (i < 3) begin
                exValid = 1'b1; exLoad = 1'b0; exTrap = 1'b0; exWen = 1'b1;
                exRd = rds[i]; exResult = res[i];
            end else begin
                drive_idle();
            end
        end
        @(negedge clk);
        testsRun++;
        if (wbValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b end: got %b want 0", wbValid); end
    endtask

    task automatic test_random();
        logic [63:0] addr;
        logic [1:0]  size;
        int kind;
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            size = 2'($urandom_range(0, 3));
            addr = {$urandom, $urandom};
            if (kind < 2) begin
                run_direct("rnd_alu", 5'($urandom), 1'($urandom), 1'b0, 1'b0, size, 1'($urandom), addr);
            end else if (kind == 2) begin
                run_direct("rnd_trap", 5'($urandom), 1'($urandom), 1'b1, 1'($urandom), size, 1'($urandom), addr);
            end else if (kind == 3 && model_misaligned(addr, size)) begin
                run_direct("rnd_mis", 5'($urandom), 1'($urandom), 1'b0, 1'b1, size, 1'($urandom), addr);
            end else begin
                addr[2:0] = addr[2:0] & ~3'((1 << size) - 1);
                run_load("rnd_load", addr, size, 1'($urandom), {$urandom, $urandom},
                         ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), 5'($urandom), 1'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_nonload();
        test_byte_load();
        test_word_delayed();
        test_faults();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
